// File: rtl/uart_tx_sb_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_sb_ctrl
//   Memory-mapped UART transmitter acting as a system-bus responder.
//   Bytes written to DATA are queued in a small FIFO and serialised on tx_o
//   as: start bit, 8 data bits LSB first, optional even-parity bit, 1 or 2
//   stop bits. A DATA write to a full FIFO is held (no ready_o) until the
//   transmitter frees a slot, which stalls the initiator.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined     : PARITY_EN register (0x0C) and the parity bit exist.
//   not defined : 0x0C reads 0 / ignores writes, no parity bit is ever sent.
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   req_i          bus request (slot already selected), held until ready_o
//   write_enable_i 1 = write, 0 = read
//   addr_i         byte address, only [7:0] decoded
//   write_data_i   write data
//   read_data_o    read data, valid while ready_o = 1
//   ready_o        one-cycle completion pulse
//   tx_o           UART serial output, idles high
//
// Register map (addr_i[7:0]):
//   0x00 DATA W, 0x04 STATUS R, 0x08 DIV R/W, 0x0C PARITY_EN R/W,
//   0x10 STOPBITS R/W, 0x24 SOFT_RST W. Anything else reads 0.
// ---------------------------------------------------------------------------
module uart_tx_sb_ctrl #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DEFAULT_DIV = 87
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        write_enable_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        ready_o,
  output logic        tx_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [15:0]   DIV_RESET     = 16'(DEFAULT_DIV);
  localparam logic [15:0]   DIV_MIN       = 16'd2;

  localparam logic [7:0] A_DATA   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_DIV    = 8'h08;
  localparam logic [7:0] A_PAR    = 8'h0C;
  localparam logic [7:0] A_STOP   = 8'h10;
  localparam logic [7:0] A_SRST   = 8'h24;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  // Bus request stage
  logic        r_pend;
  logic        r_p_we;
  logic [7:0]  r_p_addr;
  logic [15:0] r_p_wdata;
  logic        r_ready;
  logic [31:0] r_rdata;

  // FIFO
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Configuration
  logic [15:0] r_div;
  logic        r_two_stop;
  logic        w_par_en;

  // Transmit engine
  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [2:0]  r_bit_idx;
  logic [2:0]  w_bit_nxt;
  logic [7:0]  r_shift;
  logic [15:0] r_f_div;
  logic        r_f_two_stop;
  logic        r_f_par;
  logic        r_par_bit;
  logic        r_tx;
  logic        w_tx_nxt;
  logic        w_pop;
  logic        w_shift_en;

  // Decode helpers
  logic        w_accept;
  logic        w_full;
  logic        w_nempty;
  logic        w_busy;
  logic        w_is_data_wr;
  logic        w_stall;
  logic        w_done;
  logic        w_wr_done;
  logic        w_push;
  logic        w_srst;
  logic        w_pop_eff;
  logic        w_bit_end;
  logic [15:0] w_div_wr_val;
  logic [31:0] w_count_ext;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_full   = (r_count == FIFO_FULL_CNT);
  assign w_nempty = (r_count != {CW{1'b0}});
  assign w_busy   = (r_state != S_IDLE) || w_nempty;

  // The cycle that carries ready_o must not re-sample the still-held req_i.
  assign w_accept     = req_i & ~r_pend & ~r_ready;
  assign w_is_data_wr = r_pend & r_p_we & (r_p_addr == A_DATA);
  assign w_stall      = w_is_data_wr & w_full;
  assign w_done       = r_pend & ~w_stall;
  assign w_wr_done    = w_done & r_p_we;
  assign w_push       = w_is_data_wr & ~w_full;
  assign w_srst       = w_wr_done & (r_p_addr == A_SRST);
  assign w_pop_eff    = w_pop & ~w_srst;
  assign w_bit_end    = (r_cnt == 16'd0);
  assign w_div_wr_val = (r_p_wdata < DIV_MIN) ? DIV_MIN : r_p_wdata;
  assign w_count_ext  = 32'(r_count);

  assign ready_o     = r_ready;
  assign read_data_o = r_rdata;
  assign tx_o        = r_tx;

  assign w_unused = ^{addr_i[31:8], write_data_i[31:16], w_count_ext[31:4],
                      r_f_par, r_par_bit};

  // Capture a new request; it stays pending while a DATA write waits for room.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend    <= 1'b0;
      r_p_we    <= 1'b0;
      r_p_addr  <= 8'h00;
      r_p_wdata <= 16'h0000;
    end else if (w_accept) begin
      r_pend    <= 1'b1;
      r_p_we    <= write_enable_i;
      r_p_addr  <= addr_i[7:0];
      r_p_wdata <= write_data_i[15:0];
    end else if (w_done) begin
      r_pend    <= 1'b0;
    end
  end

  // Read mux over the register map, evaluated when a read completes.
  always_comb begin
    w_rdata = 32'h0000_0000;
    if (r_pend && !r_p_we) begin
      case (r_p_addr)
        A_STATUS: w_rdata = {24'h00_0000, w_count_ext[3:0], 2'b00, w_full, w_busy};
        A_DIV:    w_rdata = {16'h0000, r_div};
        A_PAR:    w_rdata = {31'h0000_0000, w_par_en};
        A_STOP:   w_rdata = {31'h0000_0000, r_two_stop};
        default:  w_rdata = 32'h0000_0000;
      endcase
    end else begin
      w_rdata = 32'h0000_0000;
    end
  end

  // Registered completion pulse and read data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ready <= 1'b0;
      r_rdata <= 32'h0000_0000;
    end else begin
      r_ready <= w_done;
      r_rdata <= w_done ? w_rdata : 32'h0000_0000;
    end
  end

  // Configuration registers; soft reset leaves them untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_div      <= DIV_RESET;
      r_two_stop <= 1'b0;
    end else if (w_wr_done) begin
      case (r_p_addr)
        A_DIV:   r_div      <= w_div_wr_val;
        A_STOP:  r_two_stop <= r_p_wdata[0];
        default: r_div      <= r_div;
      endcase
    end
  end

`ifdef UART_TX_PARITY_EN
  logic r_par_en;

  // Parity enable register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_par_en <= 1'b0;
    end else if (w_wr_done && (r_p_addr == A_PAR)) begin
      r_par_en <= r_p_wdata[0];
    end
  end

  assign w_par_en = r_par_en;
`else
  assign w_par_en = 1'b0;
`endif

  // FIFO storage and pointers; a push and a pop in one cycle leave the count unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem[i] <= 8'h00;
      end
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (w_srst) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_p_wdata[7:0];
        r_wr_ptr        <= r_wr_ptr + PW'(1'b1);
      end
      if (w_pop_eff) begin
        r_rd_ptr <= r_rd_ptr + PW'(1'b1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop_eff);
    end
  end

  // Next-state, bit timing and next line level for the transmit engine.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit_idx;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    w_shift_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_nempty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_cnt_nxt   = r_div - 16'd1;
          w_bit_nxt   = 3'd0;
          w_tx_nxt    = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
          w_tx_nxt    = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = r_f_div - 16'd1;
          w_bit_nxt   = 3'd0;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_cnt_nxt   = r_cnt - 16'd1;
          w_tx_nxt    = 1'b0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt = r_f_div - 16'd1;
          if (r_bit_idx == 3'd7) begin
            w_bit_nxt = 3'd0;
`ifdef UART_TX_PARITY_EN
            if (r_f_par) begin
              w_state_nxt = S_PARITY;
              w_tx_nxt    = r_par_bit;
            end else begin
              w_state_nxt = S_STOP;
              w_tx_nxt    = 1'b1;
            end
`else
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            // Next data bit sits one position up until the shift lands.
            w_bit_nxt  = r_bit_idx + 3'd1;
            w_shift_en = 1'b1;
            w_tx_nxt   = r_shift[1];
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_cnt_nxt   = r_f_div - 16'd1;
          w_bit_nxt   = 3'd0;
          w_tx_nxt    = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_f_two_stop && (r_bit_idx == 3'd0)) begin
            w_bit_nxt   = 3'd1;
            w_cnt_nxt   = r_f_div - 16'd1;
            w_tx_nxt    = 1'b1;
          end else if (w_nempty) begin
            // Back-to-back: next start bit follows the last stop clock directly.
            w_pop       = 1'b1;
            w_state_nxt = S_START;
            w_cnt_nxt   = r_div - 16'd1;
            w_bit_nxt   = 3'd0;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_bit_nxt   = 3'd0;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 16'd0;
        w_bit_nxt   = 3'd0;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // Transmit engine state; soft reset aborts the frame and idles the line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'd0;
      r_bit_idx <= 3'd0;
      r_tx      <= 1'b1;
    end else if (w_srst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'd0;
      r_bit_idx <= 3'd0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  // Per-frame snapshot: the byte, its parity and the configuration in force at pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shift      <= 8'h00;
      r_par_bit    <= 1'b0;
      r_f_div      <= DIV_RESET;
      r_f_two_stop <= 1'b0;
      r_f_par      <= 1'b0;
    end else if (w_pop_eff) begin
      r_shift      <= r_mem[r_rd_ptr];
      r_par_bit    <= even_parity(r_mem[r_rd_ptr]);
      r_f_div      <= r_div;
      r_f_two_stop <= r_two_stop;
      r_f_par      <= w_par_en;
    end else if (w_shift_en) begin
      r_shift      <= {1'b0, r_shift[7:1]};
    end
  end

endmodule
